fetch_bp_1bit: RTL and testbench

//  Fetch-side counterpart of the instruction memory: generates the fetch PC and drives the

---
 rtl/fetch_bp_1bit_pkg.sv | 28 ++
 rtl/fetch_bp_1bit_bht.sv | 62 ++++++
 rtl/fetch_bp_1bit.sv | 135 +++++++++++++
 tb/tb_fetch_bp_1bit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_bp_1bit_pkg.sv
// Shared types and defaults for the fetch stage and its 1-bit branch history table.
// Tags are held at their widest possible width so one entry type fits any table depth.
package fetch_pkg;

  localparam int          BHT_IDX_W_DEFAULT = 6;
  localparam int          BHT_TAG_W_DEFAULT = 32 - BHT_IDX_W_DEFAULT - 2;
  localparam int          BHT_TAG_MAX_W     = 30;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0;

  typedef struct packed {
    logic                     valid;
    logic [BHT_TAG_MAX_W-1:0] tag;
    logic                     taken;
    logic [31:0]              target;
  } bht_entry_t;

  // Tag is everything above the index and byte-offset bits, zero-extended.
  function automatic logic [BHT_TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
    logic [31:0] shifted;
    shifted = pc >> (idx_w + 2);
    return shifted[BHT_TAG_MAX_W-1:0];
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_bp_1bit_bht.sv
// Direct-mapped 1-bit branch history table: combinational read port, edge write port.
// Only the valid vector is reset; tag/direction/target storage is plain memory.
module bht_1bit
  import fetch_pkg::*;
#(
  parameter int IDX_W = BHT_IDX_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic             wr_target_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  bht_entry_t       wr_entry
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]         valid_reg;
  logic [DEPTH-1:0]         valid_next;
  logic [DEPTH-1:0]         wr_sel;
  logic [BHT_TAG_MAX_W-1:0] tag_mem    [DEPTH];
  logic                     taken_mem  [DEPTH];
  logic [31:0]              target_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi]     = wr_en && (wr_idx == IDX_W'(gi));
      assign valid_next[gi] = wr_sel[gi] ? wr_entry.valid : valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // A not-taken update keeps the previously learned target.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]   <= wr_entry.tag;
      taken_mem[wr_idx] <= wr_entry.taken;
      if (wr_target_en) begin
        target_mem[wr_idx] <= wr_entry.target;
      end
    end
  end

  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_reg[rd_idx];
    rd_entry.tag    = tag_mem[rd_idx];
    rd_entry.taken  = taken_mem[rd_idx];
    rd_entry.target = target_mem[rd_idx];
  end

endmodule

// File: rtl/fetch_bp_1bit.sv
// Fetch PC generator with 1-bit branch prediction, EX-side redirect and flush control.
// Decode-side PC/prediction registers line up with the instruction memory's registered output.
module fetch_bp_1bit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BHT_IDX_W = BHT_IDX_W_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_ex_br_valid,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic [31:0] o_pc,
  output logic        o_stall_decode,
  output logic        o_flush_decode,
  output logic        o_flush_execute,
  output logic [31:0] o_pc_decode,
  output logic        o_pred_taken_dec,
  output logic [31:0] o_pred_target_dec,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = BHT_IDX_W + 1;

  logic [31:0]          pc_reg, pc_next;
  logic [31:0]          pc_dec_reg, pc_dec_next;
  logic                 pred_taken_dec_reg, pred_taken_dec_next;
  logic [31:0]          pred_target_dec_reg, pred_target_dec_next;
  logic [31:0]          br_cnt_reg, mispred_cnt_reg;

  logic [BHT_IDX_W-1:0] fetch_idx, ex_idx;
  bht_entry_t           rd_entry, wr_entry;
  logic                 hit, pred_taken;
  logic [31:0]          pred_target;
  logic                 mispredict;
  logic [31:0]          redirect_pc;

  assign fetch_idx = pc_reg[IDX_MSB:IDX_LSB];
  assign ex_idx    = i_ex_pc[IDX_MSB:IDX_LSB];

  bht_1bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .rd_idx       (fetch_idx),
    .rd_entry     (rd_entry),
    .wr_en        (i_ex_br_valid),
    .wr_target_en (i_ex_taken),
    .wr_idx       (ex_idx),
    .wr_entry     (wr_entry)
  );

  always_comb begin
    wr_entry        = '0;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = pc_tag(i_ex_pc, BHT_IDX_W);
    wr_entry.taken  = i_ex_taken;
    wr_entry.target = word_align(i_ex_target);
  end

  assign hit         = rd_entry.valid && (rd_entry.tag == pc_tag(pc_reg, BHT_IDX_W));
  assign pred_taken  = hit && rd_entry.taken;
  assign pred_target = rd_entry.target;

  // A wrong target only matters when the branch was actually taken.
  assign mispredict = i_ex_br_valid &&
                      ((i_ex_taken != i_ex_pred_taken) ||
                       (i_ex_taken && (i_ex_target != i_ex_pred_target)));

  assign redirect_pc = i_ex_taken ? word_align(i_ex_target) : word_align(i_ex_pc + 32'd4);

  always_comb begin
    pc_next = pc_reg;
    if (mispredict) begin
      pc_next = redirect_pc;
    end else if (i_stall) begin
      pc_next = pc_reg;
    end else if (pred_taken) begin
      pc_next = word_align(pred_target);
    end else begin
      pc_next = word_align(pc_reg + 32'd4);
    end
  end

  // Flush wins over stall so a redirect never leaves a wrong-path instruction in decode.
  always_comb begin
    pc_dec_next          = pc_dec_reg;
    pred_taken_dec_next  = pred_taken_dec_reg;
    pred_target_dec_next = pred_target_dec_reg;
    if (mispredict) begin
      pc_dec_next          = '0;
      pred_taken_dec_next  = 1'b0;
      pred_target_dec_next = '0;
    end else if (!i_stall) begin
      pc_dec_next          = pc_reg;
      pred_taken_dec_next  = pred_taken;
      pred_target_dec_next = pred_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_reg              <= RESET_PC;
      pc_dec_reg          <= '0;
      pred_taken_dec_reg  <= 1'b0;
      pred_target_dec_reg <= '0;
      br_cnt_reg          <= '0;
      mispred_cnt_reg     <= '0;
    end else begin
      pc_reg              <= pc_next;
      pc_dec_reg          <= pc_dec_next;
      pred_taken_dec_reg  <= pred_taken_dec_next;
      pred_target_dec_reg <= pred_target_dec_next;
      br_cnt_reg          <= br_cnt_reg + {31'd0, i_ex_br_valid};
      mispred_cnt_reg     <= mispred_cnt_reg + {31'd0, mispredict};
    end
  end

  assign o_pc              = pc_reg;
  assign o_stall_decode    = i_stall && !mispredict;
  assign o_flush_decode    = mispredict;
  assign o_flush_execute   = mispredict;
  assign o_pc_decode       = pc_dec_reg;
  assign o_pred_taken_dec  = pred_taken_dec_reg;
  assign o_pred_target_dec = pred_target_dec_reg;
  assign o_br_cnt          = br_cnt_reg;
  assign o_mispred_cnt     = mispred_cnt_reg;

endmodule

// File: tb/tb_fetch_bp_1bit.sv
// Directed and randomized checks of fetch_bp_1bit against a table-of-entries reference model.
module tb_fetch_bp_1bit;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall, i_ex_br_valid, i_ex_taken, i_ex_pred_taken;
  logic [31:0] i_ex_pc, i_ex_target, i_ex_pred_target;
  logic [31:0] o_pc, o_pc_decode, o_pred_target_dec, o_br_cnt, o_mispred_cnt;
  logic        o_stall_decode, o_flush_decode, o_flush_execute, o_pred_taken_dec;

  fetch_bp_1bit #(.RESET_PC(32'h0), .BHT_IDX_W(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall),
    .i_ex_br_valid(i_ex_br_valid), .i_ex_pc(i_ex_pc), .i_ex_taken(i_ex_taken),
    .i_ex_target(i_ex_target), .i_ex_pred_taken(i_ex_pred_taken),
    .i_ex_pred_target(i_ex_pred_target), .o_pc(o_pc), .o_stall_decode(o_stall_decode),
    .o_flush_decode(o_flush_decode), .o_flush_execute(o_flush_execute),
    .o_pc_decode(o_pc_decode), .o_pred_taken_dec(o_pred_taken_dec),
    .o_pred_target_dec(o_pred_target_dec), .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: 64 entries addressed by word number mod 64, tag = address / 256.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  bit          m_taken [64];
  int unsigned m_tgt   [64];
  bit          m_known [64];
  int unsigned m_pc, m_dpc, m_dtgt, m_br, m_mp;
  bit          m_dpt, m_dknown;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_dpc = 0; m_dtgt = 0; m_dpt = 0; m_dknown = 1;
    m_br = 0; m_mp = 0;
    for (int k = 0; k < 64; k++) m_valid[k] = 0;
  endtask

  task automatic model_pred(input int unsigned pc, output bit pt, output int unsigned ptg);
    int unsigned k;
    k   = (pc / 4) % 64;
    pt  = m_valid[k] && (m_tag[k] == pc / 256) && m_taken[k];
    ptg = m_known[k] ? m_tgt[k] : 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, o_pc, m_pc);
    chk({tag, ".pc_dec"}, o_pc_decode, m_dpc);
    chk({tag, ".pred_taken_dec"}, {31'd0, o_pred_taken_dec}, {31'd0, m_dpt});
    if (m_dknown) chk({tag, ".pred_target_dec"}, o_pred_target_dec, m_dtgt);
    chk({tag, ".br_cnt"}, o_br_cnt, m_br);
    chk({tag, ".mispred_cnt"}, o_mispred_cnt, m_mp);
  endtask

  // One clock: drive inputs, check the combinational controls, advance model, check state.
  task automatic cycle(input bit stall, input bit bv, input int unsigned epc, input bit tk,
                       input int unsigned tgt, input bit ptk, input int unsigned ptgt,
                       input string tag);
    bit          mp, pt;
    int unsigned k, ptg;
    i_stall = stall; i_ex_br_valid = bv; i_ex_pc = epc; i_ex_taken = tk;
    i_ex_target = tgt; i_ex_pred_taken = ptk; i_ex_pred_target = ptgt;
    #1;
    mp = bv && ((tk != ptk) || (tk && tgt != ptgt));
    chk({tag, ".flush_dec"}, {31'd0, o_flush_decode}, {31'd0, mp});
    chk({tag, ".flush_ex"}, {31'd0, o_flush_execute}, {31'd0, mp});
    chk({tag, ".stall_dec"}, {31'd0, o_stall_decode}, {31'd0, stall && !mp});
    model_pred(m_pc, pt, ptg);
    k = (m_pc / 4) % 64;
    if (mp) begin
      m_dpc = 0; m_dpt = 0; m_dtgt = 0; m_dknown = 1;
    end else if (!stall) begin
      m_dpc = m_pc; m_dpt = pt; m_dtgt = ptg; m_dknown = m_known[k];
    end
    if (mp) m_pc = tk ? (tgt & 32'hFFFF_FFFC) : ((epc + 4) & 32'hFFFF_FFFC);
    else if (!stall) m_pc = pt ? ptg : m_pc + 4;
    if (bv) begin
      k = (epc / 4) % 64;
      m_valid[k] = 1; m_tag[k] = epc / 256; m_taken[k] = tk;
      if (tk) begin
        m_tgt[k] = tgt & 32'hFFFF_FFFC; m_known[k] = 1;
      end
      m_br++;
    end
    if (mp) m_mp++;
    @(posedge i_clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    bit          st, bv, tk, ptk;
    int unsigned epc, tgt, ptgt;
    logic [31:0] held_pc, held_dpc;
    i_reset = 0; i_stall = 0; i_ex_br_valid = 0; i_ex_pc = 0; i_ex_taken = 0;
    i_ex_target = 0; i_ex_pred_taken = 0; i_ex_pred_target = 0;
    for (int k = 0; k < 64; k++) begin m_known[k] = 0; m_tgt[k] = 0; end
    model_reset();
    #2;
    check_state("reset");
    chk("reset.flush", {31'd0, o_flush_decode}, 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1;

    // Sequential fetch after reset
    for (int k = 0; k < 4; k++) begin
      idle("seq");
      chk("seq.pc_const", o_pc, 32'(4 * (k + 1)));
      chk("seq.dec_const", o_pc_decode, 32'(4 * k));
    end

    // Taken branch 0x10 -> 0x40 with no prediction, then refetch 0x10
    cycle(0, 1, 32'h10, 1, 32'h40, 0, 0, "br_taken");
    chk("br_taken.pc_const", o_pc, 32'h40);
    chk("br_taken.dec_const", o_pc_decode, 32'h0);
    chk("br_taken.mp_const", o_mispred_cnt, 32'd1);
    cycle(0, 1, 32'h30, 1, 32'h10, 0, 0, "jump_to_10");
    idle("refetch");
    chk("refetch.dec_const", o_pc_decode, 32'h10);
    chk("refetch.pt_const", {31'd0, o_pred_taken_dec}, 32'd1);
    chk("refetch.tgt_const", o_pred_target_dec, 32'h40);
    chk("refetch.pc_const", o_pc, 32'h40);

    // Same branch resolves not-taken with taken prediction
    cycle(0, 1, 32'h10, 0, 0, 1, 32'h40, "br_nt");
    chk("br_nt.pc_const", o_pc, 32'h14);
    cycle(0, 1, 32'h30, 1, 32'h10, 0, 0, "jump_to_10b");
    idle("refetch_nt");
    chk("refetch_nt.pt_const", {31'd0, o_pred_taken_dec}, 32'd0);
    chk("refetch_nt.pc_const", o_pc, 32'h14);

    // Stall holds PC and decode, then a mispredict during stall still redirects
    held_pc = o_pc; held_dpc = o_pc_decode;
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, "stall");
      chk("stall.pc_hold", o_pc, held_pc);
      chk("stall.dec_hold", o_pc_decode, held_dpc);
    end
    cycle(1, 1, 32'h20, 1, 32'h80, 0, 0, "stall_mp");
    chk("stall_mp.pc_const", o_pc, 32'h80);

    // Aliasing: 0x10 and 0x110 share an index
    cycle(0, 1, 32'h10, 1, 32'h40, 0, 0, "alias_train");
    cycle(0, 1, 32'h30, 1, 32'h110, 0, 0, "alias_jump");
    idle("alias_lookup");
    chk("alias_lookup.pt_const", {31'd0, o_pred_taken_dec}, 32'd0);
    chk("alias_lookup.pc_const", o_pc, 32'h114);
    cycle(0, 1, 32'h110, 1, 32'h200, 0, 0, "alias_evict");
    cycle(0, 1, 32'h30, 1, 32'h10, 0, 0, "alias_back");
    idle("alias_after");
    chk("alias_after.pt_const", {31'd0, o_pred_taken_dec}, 32'd0);
    chk("alias_after.pc_const", o_pc, 32'h14);

    // Reset asserted while a redirect is being presented
    i_stall = 0; i_ex_br_valid = 1; i_ex_pc = 32'h20; i_ex_taken = 1;
    i_ex_target = 32'h80; i_ex_pred_taken = 0; i_ex_pred_target = 0;
    #1;
    i_reset = 0;
    #1;
    chk("midrst.pc", o_pc, 32'h0);
    chk("midrst.dec", o_pc_decode, 32'h0);
    chk("midrst.pt", {31'd0, o_pred_taken_dec}, 32'd0);
    chk("midrst.br_cnt", o_br_cnt, 32'd0);
    chk("midrst.mp_cnt", o_mispred_cnt, 32'd0);
    i_ex_br_valid = 0; i_ex_taken = 0;
    model_reset();
    @(posedge i_clk);
    #1;
    check_state("midrst_hold");
    @(negedge i_clk);
    i_reset = 1;
    cycle(0, 1, 32'h30, 1, 32'h110, 0, 0, "post_rst_jump");
    idle("post_rst_lookup");
    chk("post_rst.pt_const", {31'd0, o_pred_taken_dec}, 32'd0);
    chk("post_rst.pc_const", o_pc, 32'h114);

    // PC increment wraps at 2^32
    cycle(0, 1, 32'h30, 1, 32'hFFFF_FFF8, 0, 0, "wrap_jump");
    idle("wrap1");
    idle("wrap2");
    chk("wrap.pc_const", o_pc, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      st  = ($urandom_range(0, 4) == 0);
      bv  = ($urandom_range(0, 9) < 4);
      epc = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 8);
      tk  = $urandom_range(0, 1);
      tgt = $urandom_range(0, 127) << 2;
      if ($urandom_range(0, 1) == 1) model_pred(epc, ptk, ptgt);
      else begin
        ptk  = $urandom_range(0, 1);
        ptgt = $urandom_range(0, 127) << 2;
      end
      cycle(st, bv, epc, tk, tgt, ptk, ptgt, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
